// File: rtl/bram_capture_reader_pkg.sv
// Shared types for the BRAM capture/readout front-end.
package bram_capture_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/bram_capture_reader_skid_fifo.sv
// Small synchronous first-word fall-through FIFO that absorbs RAM read latency.
module sync_skid_fifo #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COUNT_W = 3
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_pop,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic [COUNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;
  logic [COUNT_W-1:0] count;
  logic               pop_ok;

  assign pop_ok  = i_pop && (count != '0);
  assign o_valid = (count != '0);
  assign o_data  = (count != '0) ? mem[rd_idx] : '0;
  assign o_count = count;

  always_ff @(posedge clk) begin
    if (i_push) mem[wr_idx] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (i_push) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      if (pop_ok) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      if (i_push && !pop_ok)      count <= count + 1'b1;
      else if (!i_push && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bram_capture_reader.sv
// Captures a sample stream into block RAM, then drains it over a valid/ready stream.
module bram_capture_reader
  import bram_capture_reader_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 32768,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned SKID_DEPTH = 4,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_sample_valid,
  input  logic              i_read_start,
  output logic [ADDR_W-1:0] o_ram_write_addr,
  output logic [DATA_W-1:0] o_ram_data_input,
  output logic              o_ram_write_en,
  output logic [ADDR_W-1:0] o_ram_read_addr,
  output logic              o_ram_read_en,
  input  logic [DATA_W-1:0] i_ram_data_output,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_full
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  SKID_LIMIT = CNT_W'(SKID_DEPTH);

  state_t             state, next_state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    issued;
  logic [RD_LAT-1:0]  vpipe;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   inflight;
  logic               issue;
  logic               push;
  logic               pop;

  assign push = vpipe[RD_LAT-1];
  assign pop  = o_valid && i_ready;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vpipe[i]);
  end

  always_ff @(posedge clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (i_start) next_state = ST_CAPTURE;
      ST_CAPTURE: if (i_sample_valid && wr_ptr == LAST_ADDR) next_state = ST_FULL;
      ST_FULL:    if (i_read_start) next_state = ST_READOUT;
      ST_READOUT: if (issued == DEPTH_CNT && fifo_count == '0 && inflight == '0)
                    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Credit check counts reads still in the RAM pipe so the FIFO can never overflow.
  always_comb begin
    o_busy = 1'b0;
    o_full = 1'b0;
    issue  = 1'b0;
    unique case (state)
      ST_CAPTURE: o_busy = 1'b1;
      ST_FULL:    o_full = 1'b1;
      ST_READOUT: begin
        o_busy = 1'b1;
        issue  = (issued < DEPTH_CNT) && ((fifo_count + inflight) < SKID_LIMIT);
      end
      default: ;
    endcase
  end

  assign o_ram_read_en   = issue;
  assign o_ram_read_addr = rd_ptr;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      issued           <= '0;
      vpipe            <= '0;
      o_ram_write_en   <= 1'b0;
      o_ram_write_addr <= '0;
      o_ram_data_input <= '0;
    end else begin
      o_ram_write_en <= 1'b0;
      unique case (state)
        ST_IDLE: if (i_start) wr_ptr <= '0;
        ST_CAPTURE: if (i_sample_valid) begin
          o_ram_write_en   <= 1'b1;
          o_ram_write_addr <= wr_ptr;
          o_ram_data_input <= i_sample;
          wr_ptr           <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
        end
        ST_FULL: if (i_read_start) begin
          rd_ptr <= '0;
          issued <= '0;
        end
        ST_READOUT: if (issue) begin
          rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
          issued <= issued + 1'b1;
        end
        default: ;
      endcase
      vpipe[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  sync_skid_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (SKID_DEPTH),
    .COUNT_W (CNT_W)
  ) u_skid (
    .clk     (clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (i_ram_data_output),
    .i_pop   (pop),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_count (fifo_count)
  );

endmodule
